// File: rtl/hazard_stall_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_if
//
// Purpose
//    Bundles the pipeline-side signals of the stall/flush sequencer so the
//    core and the sequencer share one connection point. Clock and reset are
//    not part of the bundle; they stay plain ports on the sequencer.
//
// Signals (direction as seen by the sequencer, modport slave)
//    start_i          in   1      core start, only looked at while idle
//    IFID_rs1_i       in   REG_W  rs1 of the instruction in ID
//    IFID_rs2_i       in   REG_W  rs2 of the instruction in ID
//    IDEX_MemRead_i   in   1      instruction in EX is a load
//    IDEX_rd_i        in   REG_W  rd of the instruction in EX
//    branch_taken_i   in   1      branch resolved taken in ID this cycle
//    mem_busy_i       in   1      data memory has not completed this cycle
//    pc_write_o       out  1      PC register write enable
//    ifid_write_o     out  1      IF/ID register write enable
//    ifid_flush_o     out  1      IF/ID register clear (NOP insert)
//    bubble_o         out  1      zeroes ID control going into ID/EX
//    pipe_hold_o      out  1      freezes ID/EX, EX/MEM and MEM/WB
//    err_o            out  1      sticky data-memory timeout error
//    state_o          out  2      00 IDLE, 01 RUN, 10 MEM_WAIT, 11 ERROR
//    lu_cnt_o         out  CNT_W  load-use bubbles inserted
//    memwait_cnt_o    out  CNT_W  cycles frozen on mem_busy_i
//    flush_cnt_o      out  CNT_W  IF/ID flushes issued
//
// Modports
//    master  the pipeline side: drives the *_i signals, reads the *_o signals
//    slave   the sequencer side: reads the *_i signals, drives the *_o signals
// ----------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);

   logic             start_i;
   logic [REG_W-1:0] IFID_rs1_i;
   logic [REG_W-1:0] IFID_rs2_i;
   logic             IDEX_MemRead_i;
   logic [REG_W-1:0] IDEX_rd_i;
   logic             branch_taken_i;
   logic             mem_busy_i;

   logic             pc_write_o;
   logic             ifid_write_o;
   logic             ifid_flush_o;
   logic             bubble_o;
   logic             pipe_hold_o;
   logic             err_o;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] lu_cnt_o;
   logic [CNT_W-1:0] memwait_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport master (
      output start_i,
      output IFID_rs1_i,
      output IFID_rs2_i,
      output IDEX_MemRead_i,
      output IDEX_rd_i,
      output branch_taken_i,
      output mem_busy_i,
      input  pc_write_o,
      input  ifid_write_o,
      input  ifid_flush_o,
      input  bubble_o,
      input  pipe_hold_o,
      input  err_o,
      input  state_o,
      input  lu_cnt_o,
      input  memwait_cnt_o,
      input  flush_cnt_o
   );

   modport slave (
      input  start_i,
      input  IFID_rs1_i,
      input  IFID_rs2_i,
      input  IDEX_MemRead_i,
      input  IDEX_rd_i,
      input  branch_taken_i,
      input  mem_busy_i,
      output pc_write_o,
      output ifid_write_o,
      output ifid_flush_o,
      output bubble_o,
      output pipe_hold_o,
      output err_o,
      output state_o,
      output lu_cnt_o,
      output memwait_cnt_o,
      output flush_cnt_o
   );

endinterface

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Purpose
//    Central stall/flush sequencer for the 5-stage pipeline. Detects load-use
//    hazards and inserts a bubble in ID, drives the PC and IF/ID write enables
//    and the IF/ID flush, freezes the back half of the pipeline while data
//    memory is busy, keeps three saturating event counters, and parks the core
//    in ERROR when data memory stays busy for MEM_TIMEOUT consecutive cycles.
//
// Parameters
//    REG_W        register-address width (must match the interface)
//    CNT_W        width of each saturating counter (must match the interface)
//    MEM_TIMEOUT  consecutive busy cycles that raise err_o (>= 2)
//
// Ports
//    clk_i   in   1   clock, rising edge
//    rst_i   in   1   asynchronous reset, active low
//    bus     slave modport of hazard_stall_ctrl_if carrying all hazard
//            inputs, enable/flush/bubble/hold outputs, error, state and
//            counters
//
// All enable/bubble/hold/flush outputs are combinational from the current
// state and the current inputs, so a stall takes effect in the same cycle the
// hazard is seen.
// ----------------------------------------------------------------------------
module hazard_stall_ctrl #(
   parameter int REG_W       = 5,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   hazard_stall_ctrl_if.slave   bus
);

   // Wide enough to hold MEM_TIMEOUT-1 with a spare bit.
   localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_RUN      = 2'b01,
      ST_MEM_WAIT = 2'b10,
      ST_ERROR    = 2'b11
   } stateT;

   stateT             r_state;
   stateT             w_nextState;
   logic [WAIT_W-1:0] r_waitCnt;
   logic [WAIT_W-1:0] w_waitNext;
   logic              r_err;
   logic              w_errSet;

   logic              w_loadUse;
   logic              w_pcWrite;
   logic              w_ifidWrite;
   logic              w_flush;
   logic              w_bubble;
   logic              w_hold;

   // One-hot "which decode case won this cycle" flags feeding the counters.
   logic              w_selBusy;
   logic              w_selLu;
   logic              w_selBr;

   logic [CNT_W-1:0]  r_luCnt;
   logic [CNT_W-1:0]  r_memWaitCnt;
   logic [CNT_W-1:0]  r_flushCnt;

   // Load-use hazard: a load in EX writes a register that the instruction in
   // ID reads. x0 is never a real dependency, so rd == 0 never stalls.
   always_comb begin
      w_loadUse = bus.IDEX_MemRead_i
                & (bus.IDEX_rd_i != REG_W'(0))
                & ((bus.IDEX_rd_i == bus.IFID_rs1_i) | (bus.IDEX_rd_i == bus.IFID_rs2_i));
   end

   // Next-state and output decode. RUN and MEM_WAIT share one decode so that
   // the cycle in which memory releases is already treated as a normal RUN
   // cycle, giving no dead cycle after a memory stall. Priority is memory
   // busy, then load-use, then taken branch; a load-use stall swallows a
   // simultaneous branch because the branch will be re-resolved once the
   // stalled instruction is re-decoded.
   always_comb begin
      w_nextState = r_state;
      w_waitNext  = r_waitCnt;
      w_errSet    = 1'b0;
      w_pcWrite   = 1'b0;
      w_ifidWrite = 1'b0;
      w_flush     = 1'b0;
      w_bubble    = 1'b0;
      w_hold      = 1'b0;
      w_selBusy   = 1'b0;
      w_selLu     = 1'b0;
      w_selBr     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_bubble = 1'b1;
            if (bus.start_i) begin
               w_nextState = ST_RUN;
            end
         end

         ST_RUN, ST_MEM_WAIT: begin
            if (bus.mem_busy_i) begin
               w_hold    = 1'b1;
               w_selBusy = 1'b1;
               // The wait counter holds the number of busy cycles already
               // seen, so hitting MEM_TIMEOUT-1 here means this is the
               // MEM_TIMEOUT-th consecutive busy cycle.
               if (r_waitCnt == WAIT_LAST) begin
                  w_nextState = ST_ERROR;
                  w_errSet    = 1'b1;
               end else begin
                  w_nextState = ST_MEM_WAIT;
                  w_waitNext  = r_waitCnt + WAIT_W'(1);
               end
            end else begin
               w_nextState = ST_RUN;
               w_waitNext  = '0;
               if (w_loadUse) begin
                  w_bubble = 1'b1;
                  w_selLu  = 1'b1;
               end else if (bus.branch_taken_i) begin
                  w_flush     = 1'b1;
                  w_pcWrite   = 1'b1;
                  w_ifidWrite = 1'b1;
                  w_selBr     = 1'b1;
               end else begin
                  w_pcWrite   = 1'b1;
                  w_ifidWrite = 1'b1;
               end
            end
         end

         ST_ERROR: begin
            w_bubble = 1'b1;
            w_hold   = 1'b1;
         end

         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // State, wait counter and sticky error. ERROR has no way out except reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= ST_IDLE;
         r_waitCnt <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_waitCnt <= w_waitNext;
         if (w_errSet) begin
            r_err <= 1'b1;
         end
      end
   end

   // Saturating event counters. The select flags are only ever raised in RUN
   // or MEM_WAIT, so IDLE and ERROR cycles never count.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_luCnt      <= '0;
         r_memWaitCnt <= '0;
         r_flushCnt   <= '0;
      end else begin
         if (w_selLu && (r_luCnt != '1)) begin
            r_luCnt <= r_luCnt + CNT_W'(1);
         end
         if (w_selBusy && (r_memWaitCnt != '1)) begin
            r_memWaitCnt <= r_memWaitCnt + CNT_W'(1);
         end
         if (w_selBr && (r_flushCnt != '1)) begin
            r_flushCnt <= r_flushCnt + CNT_W'(1);
         end
      end
   end

   // Drive the interface outputs.
   always_comb begin
      bus.pc_write_o    = w_pcWrite;
      bus.ifid_write_o  = w_ifidWrite;
      bus.ifid_flush_o  = w_flush;
      bus.bubble_o      = w_bubble;
      bus.pipe_hold_o   = w_hold;
      bus.err_o         = r_err;
      bus.state_o       = r_state;
      bus.lu_cnt_o      = r_luCnt;
      bus.memwait_cnt_o = r_memWaitCnt;
      bus.flush_cnt_o   = r_flushCnt;
   end

endmodule
